// File: rtl/icache_tag_ctrl_pkg.sv
// Shared types and constants for the icache tag pipeline: request/response
// payloads, opcodes and default geometry.
package toy_pack;

    localparam int ICACHE_WAYS       = 4;
    localparam int ICACHE_SETS       = 64;
    localparam int ICACHE_LINE_BYTES = 64;

    localparam int ICACHE_OFS_W = $clog2(ICACHE_LINE_BYTES);
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_WAY_W = $clog2(ICACHE_WAYS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - ICACHE_OFS_W;

    localparam logic [4:0] OP_FETCH    = 5'd0;
    localparam logic [4:0] OP_SNP_INV  = 5'd1;
    localparam logic [4:0] OP_PREFETCH = 5'd2;

    typedef struct packed {
        logic [31:0] addr;
        logic [4:0]  txnid;
        logic [4:0]  opcode;
    } pc_req_t;

    typedef struct packed {
        pc_req_t                 req;
        logic                    hit;
        logic [ICACHE_WAY_W-1:0] hit_way;
        logic [ICACHE_WAY_W-1:0] victim_way;
    } tag_rsp_t;

    // Unknown opcodes behave as plain fetches.
    function automatic logic [4:0] op_norm(input logic [4:0] op);
        case (op)
            OP_SNP_INV:  op_norm = OP_SNP_INV;
            OP_PREFETCH: op_norm = OP_PREFETCH;
            default:     op_norm = OP_FETCH;
        endcase
    endfunction

endpackage

// File: rtl/icache_tag_ctrl_if.sv
// Tag-request, refill and tag-response channels between the fetch/MSHR side
// (master) and the tag controller (slave).
interface icache_tag_ctrl_if;
    import toy_pack::*;

    logic                    tag_req_vld;
    logic                    tagram_req_rdy;
    pc_req_t                 tag_req_pld;

    logic                    refill_vld;
    logic                    refill_rdy;
    logic [ICACHE_IDX_W-1:0] refill_idx;
    logic [ICACHE_WAY_W-1:0] refill_way;
    logic [ICACHE_TAG_W-1:0] refill_tag;

    logic                    tag_rsp_vld;
    logic                    tag_rsp_rdy;
    tag_rsp_t                tag_rsp_pld;

    modport master (
        output tag_req_vld, tag_req_pld,
        output refill_vld, refill_idx, refill_way, refill_tag,
        output tag_rsp_rdy,
        input  tagram_req_rdy, refill_rdy, tag_rsp_vld, tag_rsp_pld
    );

    modport slave (
        input  tag_req_vld, tag_req_pld,
        input  refill_vld, refill_idx, refill_way, refill_tag,
        input  tag_rsp_rdy,
        output tagram_req_rdy, refill_rdy, tag_rsp_vld, tag_rsp_pld
    );

endinterface

// File: rtl/icache_tag_ctrl_cmp.sv
// Combinational compare of one set: hit detection, lowest hitting way, and
// victim choice (lowest invalid way, else the set's round-robin pointer).
module icache_tag_cmp #(
    parameter  int WAYS  = 4,
    parameter  int TAG_W = 20,
    localparam int WAY_W = $clog2(WAYS)
) (
    input  logic [TAG_W-1:0] set_tags [WAYS],
    input  logic [WAYS-1:0]  set_valid,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [WAY_W-1:0] rr_ptr,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAYS-1:0] match;

    // Scanning from the top way down leaves the lowest qualifying way in place.
    always_comb begin
        match      = '0;
        hit_way    = '0;
        victim_way = rr_ptr;
        for (int w = WAYS - 1; w >= 0; w--) begin
            match[w] = set_valid[w] && (set_tags[w] == req_tag);
            if (match[w]) begin
                hit_way = WAY_W'(w);
            end
            if (!set_valid[w]) begin
                victim_way = WAY_W'(w);
            end
        end
        hit = |match;
    end

endmodule

// File: rtl/icache_tag_ctrl.sv
// Icache tag controller: flop-based tag/valid array with a two-stage lookup
// (S1 request register + compare, S2 response register), refills and snoops.
module icache_tag_ctrl
    import toy_pack::*;
#(
    parameter int WAYS       = ICACHE_WAYS,
    parameter int SETS       = ICACHE_SETS,
    parameter int LINE_BYTES = ICACHE_LINE_BYTES
) (
    input  logic             clk,
    input  logic             rst,
    icache_tag_ctrl_if.slave bus
);

    localparam int OFS_W = $clog2(LINE_BYTES);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = $clog2(WAYS);
    localparam int TAG_W = 32 - IDX_W - OFS_W;

    logic [SETS-1:0][WAYS-1:0] valid;
    logic [TAG_W-1:0]          tag_arr [SETS][WAYS];
    logic [WAY_W-1:0]          rr_ptr  [SETS];

    logic                      s1_vld;
    pc_req_t                   s1_req;
    logic [IDX_W-1:0]          s1_idx;
    logic [TAG_W-1:0]          s1_tag;
    logic                      s1_adv;
    logic                      accept;
    logic                      snoop_inv;

    logic                      hit;
    logic [WAY_W-1:0]          hit_way;
    logic [WAY_W-1:0]          victim_way;

    logic                      rsp_vld;
    tag_rsp_t                  rsp_pld;

    assign s1_idx = s1_req.addr[OFS_W+IDX_W-1:OFS_W];
    assign s1_tag = s1_req.addr[31:OFS_W+IDX_W];

    // A refill owns the array for its cycle, so S1 neither advances nor accepts.
    assign s1_adv    = s1_vld && !bus.refill_vld && (!rsp_vld || bus.tag_rsp_rdy);
    assign accept    = bus.tag_req_vld && bus.tagram_req_rdy;
    assign snoop_inv = s1_adv && hit && (op_norm(s1_req.opcode) == OP_SNP_INV);

    assign bus.tagram_req_rdy = !rst && !bus.refill_vld && (!s1_vld || s1_adv);
    assign bus.refill_rdy     = !rst;
    assign bus.tag_rsp_vld    = rsp_vld;
    assign bus.tag_rsp_pld    = rsp_pld;

    icache_tag_cmp #(
        .WAYS  (WAYS),
        .TAG_W (TAG_W)
    ) u_cmp (
        .set_tags   (tag_arr[s1_idx]),
        .set_valid  (valid[s1_idx]),
        .req_tag    (s1_tag),
        .rr_ptr     (rr_ptr[s1_idx]),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_ptr[s] <= '0;
            end
        end else begin
            if (bus.refill_vld) begin
                valid[bus.refill_idx][bus.refill_way] <= 1'b1;
                rr_ptr[bus.refill_idx]                <= bus.refill_way + WAY_W'(1);
            end
            if (snoop_inv) begin
                valid[s1_idx][hit_way] <= 1'b0;
            end
        end
    end

    // Tags need no reset: they are only meaningful behind a valid bit.
    always_ff @(posedge clk) begin
        if (!rst && bus.refill_vld) begin
            tag_arr[bus.refill_idx][bus.refill_way] <= bus.refill_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_req  <= '0;
            rsp_vld <= 1'b0;
            rsp_pld <= '0;
        end else begin
            if (accept) begin
                s1_vld <= 1'b1;
                s1_req <= bus.tag_req_pld;
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end

            if (s1_adv) begin
                rsp_vld <= 1'b1;
                rsp_pld <= '{req: s1_req, hit: hit, hit_way: hit_way, victim_way: victim_way};
            end else if (bus.tag_rsp_rdy) begin
                rsp_vld <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Self-checking bench for icache_tag_ctrl: directed scenarios followed by a
// randomized phase, all checked against a transaction-level cache model.
module tb_icache_tag_ctrl;
    import toy_pack::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    icache_tag_ctrl_if bus();

    icache_tag_ctrl #(
        .WAYS       (4),
        .SETS       (64),
        .LINE_BYTES (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nVectors     = 0;
    int nMiscompares = 0;

    // Reference cache contents plus the requests awaiting lookup and the
    // resolved responses awaiting the consumer.
    bit          mValid [64][4];
    logic [19:0] mTag   [64][4];
    int          mRr    [64];
    pc_req_t     qWait  [$];
    tag_rsp_t    qOut   [$];

    task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic pc_req_t mkReq(input logic [31:0] a, input logic [4:0] t, input logic [4:0] o);
        pc_req_t r;
        r.addr   = a;
        r.txnid  = t;
        r.opcode = o;
        return r;
    endfunction

    function automatic tag_rsp_t modelLookup(input pc_req_t r);
        tag_rsp_t e;
        int idx;
        int tag;
        bit found;
        idx   = int'(r.addr[11:6]);
        tag   = int'(r.addr[31:12]);
        e     = '0;
        e.req = r;
        found = 0;
        for (int w = 0; w < 4; w++) begin
            if (!found && mValid[idx][w] && int'(mTag[idx][w]) == tag) begin
                found     = 1;
                e.hit     = 1'b1;
                e.hit_way = 2'(w);
            end
        end
        e.victim_way = 2'(mRr[idx]);
        found = 0;
        for (int w = 0; w < 4; w++) begin
            if (!found && !mValid[idx][w]) begin
                found        = 1;
                e.victim_way = 2'(w);
            end
        end
        return e;
    endfunction

    task automatic modelReset();
        for (int s = 0; s < 64; s++) begin
            mRr[s] = 0;
            for (int w = 0; w < 4; w++) begin
                mValid[s][w] = 0;
                mTag[s][w]   = '0;
            end
        end
        qWait.delete();
        qOut.delete();
    endtask

    task automatic doReset(input int n);
        rst             = 1'b1;
        bus.tag_req_vld = 1'b0;
        bus.tag_req_pld = '0;
        bus.refill_vld  = 1'b0;
        bus.refill_idx  = '0;
        bus.refill_way  = '0;
        bus.refill_tag  = '0;
        bus.tag_rsp_rdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checkOutput("rst_req_rdy", 64'(bus.tagram_req_rdy), 64'd0);
            checkOutput("rst_refill_rdy", 64'(bus.refill_rdy), 64'd0);
            if (i > 0) begin
                checkOutput("rst_rsp_vld", 64'(bus.tag_rsp_vld), 64'd0);
                checkOutput("rst_rsp_pld", 64'(bus.tag_rsp_pld), 64'd0);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        modelReset();
    endtask

    // One clock of stimulus: drive, check outputs mid-cycle, then advance the model.
    task automatic applyStimulus(input bit reqVld, input pc_req_t req,
                                 input bit refVld, input logic [5:0] ridx,
                                 input logic [1:0] rway, input logic [19:0] rtag,
                                 input bit rspRdy, output bit accepted);
        bit lookupNow;
        bit expRdy;
        pc_req_t r;
        tag_rsp_t e;
        bus.tag_req_vld = reqVld;
        bus.tag_req_pld = req;
        bus.refill_vld  = refVld;
        bus.refill_idx  = ridx;
        bus.refill_way  = rway;
        bus.refill_tag  = rtag;
        bus.tag_rsp_rdy = rspRdy;

        lookupNow = (qWait.size() != 0) && !refVld && (qOut.size() == 0 || rspRdy);
        expRdy    = !refVld && (qWait.size() == 0 || lookupNow);

        @(negedge clk);
        checkOutput("req_rdy", 64'(bus.tagram_req_rdy), 64'(expRdy));
        checkOutput("refill_rdy", 64'(bus.refill_rdy), 64'd1);
        checkOutput("rsp_vld", 64'(bus.tag_rsp_vld), 64'(qOut.size() != 0));
        if (qOut.size() != 0) begin
            checkOutput("rsp_pld", 64'(bus.tag_rsp_pld), 64'(qOut[0]));
        end

        if (qOut.size() != 0 && rspRdy) begin
            void'(qOut.pop_front());
        end
        if (lookupNow) begin
            r = qWait.pop_front();
            e = modelLookup(r);
            qOut.push_back(e);
            if (e.hit && op_norm(r.opcode) == OP_SNP_INV) begin
                mValid[int'(r.addr[11:6])][int'(e.hit_way)] = 0;
            end
        end
        if (refVld) begin
            mValid[int'(ridx)][int'(rway)] = 1;
            mTag[int'(ridx)][int'(rway)]   = rtag;
            mRr[int'(ridx)]                = (int'(rway) + 1) % 4;
        end
        accepted = reqVld && expRdy;
        if (accepted) begin
            qWait.push_back(req);
        end

        @(posedge clk);
        #1;
    endtask

    task automatic idle(input bit rspRdy);
        bit acc;
        applyStimulus(0, '0, 0, '0, '0, '0, rspRdy, acc);
    endtask

    task automatic refill(input logic [5:0] ridx, input logic [1:0] rway, input logic [19:0] rtag);
        bit acc;
        applyStimulus(0, '0, 1, ridx, rway, rtag, 1, acc);
    endtask

    task automatic request(input pc_req_t r);
        bit acc;
        applyStimulus(1, r, 0, '0, '0, '0, 1, acc);
        checkOutput("req_taken", 64'(acc), 64'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (qWait.size() != 0 || qOut.size() != 0); i++) begin
            idle(1);
        end
        checkOutput("drain_left", 64'(qWait.size() + qOut.size()), 64'd0);
    endtask

    function automatic pc_req_t randReq(input int n);
        logic [31:0] a;
        logic [4:0]  op;
        int          pick;
        a    = 32'($urandom_range(0, 3)) << 12 | 32'($urandom_range(0, 3)) << 6 | 32'($urandom_range(0, 63));
        pick = $urandom_range(0, 9);
        if (pick <= 4)      op = OP_FETCH;
        else if (pick <= 6) op = OP_SNP_INV;
        else if (pick <= 8) op = OP_PREFETCH;
        else                op = 5'($urandom_range(3, 31));
        return mkReq(a, 5'(n), op);
    endfunction

    initial begin
        pc_req_t pend;
        pc_req_t t5 [3];
        bit      havePend;
        bit      acc;
        int      k;

        doReset(3);

        // Cold miss: no valid ways, victim is way 0.
        request(mkReq(32'h0000_1040, 5'd3, OP_FETCH));
        drain();

        // Install a line, then hit it and miss a different tag in the same set.
        refill(6'd1, 2'd0, 20'h00001);
        request(mkReq(32'h0000_1040, 5'd4, OP_FETCH));
        request(mkReq(32'h0000_2040, 5'd5, OP_PREFETCH));
        drain();

        // Fill every way of set 5 so the round-robin pointer chooses the victim.
        for (int w = 0; w < 4; w++) begin
            refill(6'd5, 2'(w), 20'(w + 8));
        end
        request(mkReq(32'h0000_7140, 5'd6, OP_FETCH));
        drain();

        // Snoop invalidation immediately followed by a fetch of the same line.
        request(mkReq(32'h0000_1040, 5'd7, OP_SNP_INV));
        request(mkReq(32'h0000_1040, 5'd8, 5'd17));
        drain();

        // Consumer stalls for 5 cycles while three requests are offered.
        t5[0] = mkReq(32'h0000_1080, 5'd9,  OP_FETCH);
        t5[1] = mkReq(32'h0000_2080, 5'd10, OP_FETCH);
        t5[2] = mkReq(32'h0000_3080, 5'd11, OP_PREFETCH);
        k = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(k < 3, (k < 3) ? t5[k] : '0, 0, '0, '0, '0, 0, acc);
            if (acc) k++;
        end
        for (int c = 0; c < 20 && k < 3; c++) begin
            applyStimulus(1, t5[k], 0, '0, '0, '0, 1, acc);
            if (acc) k++;
        end
        checkOutput("stall_all_taken", 64'(k), 64'd3);
        drain();

        // Refill lands while S1 holds a miss to the same line; lookup is redone.
        request(mkReq(32'h0000_3040, 5'd12, OP_FETCH));
        applyStimulus(1, mkReq(32'h0000_5040, 5'd13, OP_FETCH), 1, 6'd1, 2'd2, 20'h00003, 1, acc);
        checkOutput("refill_blocks_req", 64'(acc), 64'd0);
        drain();

        // Reset with traffic in flight; afterwards the array is empty.
        request(mkReq(32'h0000_3040, 5'd14, OP_FETCH));
        request(mkReq(32'h0000_7140, 5'd15, OP_FETCH));
        doReset(2);
        request(mkReq(32'h0000_3040, 5'd16, OP_FETCH));
        drain();

        // Randomized traffic over a few sets and tags so hits, snoops and
        // round-robin replacement all occur.
        havePend = 0;
        pend     = '0;
        for (int c = 0; c < 1500; c++) begin
            bit          rv;
            logic [5:0]  ri;
            logic [1:0]  rw;
            logic [19:0] rt;
            if (c == 700) begin
                doReset(2);
                havePend = 0;
            end
            if (!havePend && $urandom_range(0, 3) != 0) begin
                pend     = randReq(c);
                havePend = 1;
            end
            rv = ($urandom_range(0, 5) == 0);
            ri = 6'($urandom_range(0, 3));
            rw = 2'($urandom_range(0, 3));
            rt = 20'($urandom_range(0, 3));
            applyStimulus(havePend, pend, rv, ri, rw, rt, $urandom_range(0, 3) != 0, acc);
            if (acc) havePend = 0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
